// File: rtl/alu_rr_scheduler_pkg.sv
// Shared constants for the round-robin ALU scheduler: opcodes and FSM encoding.
package alu_rr_scheduler_pkg;

  localparam logic [2:0] OP_ADD       = 3'b000;
  localparam logic [2:0] OP_SUB       = 3'b001;
  localparam logic [2:0] OP_AND       = 3'b010;
  localparam logic [2:0] OP_OR        = 3'b011;
  localparam logic [2:0] OP_NOT       = 3'b100;
  localparam logic [2:0] OP_MAX_VALID = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_rr_scheduler_rr_pick.sv
// Combinational round-robin picker: first set request at or above the pointer,
// wrapping modulo NUM_REQ.
module alu_rr_scheduler_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  // Walk candidates from farthest to nearest so the nearest match is assigned last.
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int c;
      logic [IDX_W-1:0] w_cand;
      c = int'(i_ptr) + k;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      w_cand = IDX_W'(c);
      if (i_req[w_cand]) begin
        o_idx = w_cand;
        o_any = 1'b1;
      end
    end
  end

  always_comb begin
    o_gnt = '0;
    if (o_any) o_gnt[o_idx] = 1'b1;
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one external 8-bit ALU among NUM_REQ requesters: round-robin grant,
// registered operands, captured result returned on a per-requester response channel.
module alu_rr_scheduler
  import alu_rr_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  output logic [NUM_REQ-1:0]   o_req_ready,
  input  logic [8*NUM_REQ-1:0] i_req_a,
  input  logic [8*NUM_REQ-1:0] i_req_b,
  input  logic [3*NUM_REQ-1:0] i_req_sel,
  output logic [NUM_REQ-1:0]   o_rsp_valid,
  input  logic [NUM_REQ-1:0]   i_rsp_ready,
  output logic [7:0]           o_rsp_data,
  output logic                 o_rsp_err,
  output logic [7:0]           o_alu_a,
  output logic [7:0]           o_alu_b,
  output logic [2:0]           o_alu_sel,
  input  logic [7:0]           i_alu_result,
  output logic                 o_busy,
  output logic [CNT_W-1:0]     o_op_count
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t             r_state, w_next;
  logic [IDX_W-1:0]   r_ptr, r_gnt_idx;
  logic [IDX_W-1:0]   w_pick_idx;
  logic [NUM_REQ-1:0] w_pick_oh;
  logic               w_any;
  logic               w_accept, w_rsp_hs;
  logic [7:0]         r_op_a, r_op_b;
  logic [2:0]         r_op_sel;
  logic [7:0]         r_rsp_data;
  logic               r_rsp_err;
  logic [CNT_W-1:0]   r_op_count;

  alu_rr_scheduler_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .i_req (i_req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_pick_oh),
    .o_idx (w_pick_idx),
    .o_any (w_any)
  );

  assign w_accept = (r_state == IDLE) && w_any;
  assign w_rsp_hs = (r_state == RESP) && i_rsp_ready[r_gnt_idx];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next = EXEC;
      EXEC:    w_next = RESP;
      RESP:    if (i_rsp_ready[r_gnt_idx]) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Ready is masked by reset so a held request never sees an accept while in reset.
  always_comb begin
    o_req_ready = '0;
    o_rsp_valid = '0;
    if (r_state == IDLE && i_rst_n) o_req_ready = w_pick_oh;
    if (r_state == RESP) o_rsp_valid[r_gnt_idx] = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_op_sel  <= '0;
      r_gnt_idx <= '0;
    end else if (w_accept) begin
      r_op_a    <= i_req_a[w_pick_idx*8 +: 8];
      r_op_b    <= i_req_b[w_pick_idx*8 +: 8];
      r_op_sel  <= i_req_sel[w_pick_idx*3 +: 3];
      r_gnt_idx <= w_pick_idx;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else if (r_state == EXEC) begin
      r_rsp_data <= i_alu_result;
      r_rsp_err  <= (r_op_sel > OP_MAX_VALID);
    end
  end

  // Served requester drops to lowest priority for the next arbitration.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr      <= '0;
      r_op_count <= '0;
    end else if (w_rsp_hs) begin
      r_ptr      <= (r_gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_gnt_idx + 1'b1;
      r_op_count <= r_op_count + 1'b1;
    end
  end

  assign o_alu_a    = r_op_a;
  assign o_alu_b    = r_op_b;
  assign o_alu_sel  = r_op_sel;
  assign o_rsp_data = r_rsp_data;
  assign o_rsp_err  = r_rsp_err;
  assign o_busy     = (r_state != IDLE);
  assign o_op_count = r_op_count;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed bench for alu_rr_scheduler (NUM_REQ=4, CNT_W=4) with a behavioural ALU.
module tb_alu_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [31:0] req_a, req_b;
  logic [11:0] req_sel;
  logic [7:0]  rsp_data, alu_a, alu_b, alu_result;
  logic        rsp_err, busy;
  logic [2:0]  alu_sel;
  logic [3:0]  op_count;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  alu_rr_scheduler #(.NUM_REQ(4), .CNT_W(4)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_a      (req_a),
    .i_req_b      (req_b),
    .i_req_sel    (req_sel),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_data   (rsp_data),
    .o_rsp_err    (rsp_err),
    .o_alu_a      (alu_a),
    .o_alu_b      (alu_b),
    .o_alu_sel    (alu_sel),
    .i_alu_result (alu_result),
    .o_busy       (busy),
    .o_op_count   (op_count)
  );

  always_comb begin
    case (alu_sel)
      3'b000:  alu_result = alu_a + alu_b;
      3'b001:  alu_result = alu_a - alu_b;
      3'b010:  alu_result = alu_a & alu_b;
      3'b011:  alu_result = alu_a | alu_b;
      3'b100:  alu_result = ~alu_a;
      default: alu_result = 8'h00;
    endcase
  end

  typedef struct {
    int         idx;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] sel;
    logic [7:0] d;
    logic       e;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic load(input int idx, input logic [7:0] a, input logic [7:0] b, input logic [2:0] sel);
    req_a[idx*8 +: 8]   = a;
    req_b[idx*8 +: 8]   = b;
    req_sel[idx*3 +: 3] = sel;
  endtask

  // Entered at a negedge with the DUT idle; leaves at a negedge with the DUT idle.
  task automatic run_single(input vec_t v);
    req_valid = '0;
    req_valid[v.idx] = 1'b1;
    load(v.idx, v.a, v.b, v.sel);
    #1;
    chk("accept_ready", req_ready, 32'(1) << v.idx);
    @(negedge clk);
    req_valid = '0;
    chk("exec_ready", req_ready, 0);
    chk("exec_valid", rsp_valid, 0);
    chk("exec_busy", busy, 1);
    chk("exec_alu", {alu_a, alu_b, 5'b0, alu_sel}, {v.a, v.b, 5'b0, v.sel});
    @(negedge clk);
    chk("resp_valid", rsp_valid, 32'(1) << v.idx);
    chk("resp_data", rsp_data, v.d);
    chk("resp_err", rsp_err, v.e);
    rsp_ready = '0;
    rsp_ready[v.idx] = 1'b1;
    @(negedge clk);
    exp_cnt++;
    chk("done_count", op_count, exp_cnt % 16);
    chk("done_busy", busy, 0);
    chk("done_valid", rsp_valid, 0);
    rsp_ready = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int ng;
    int last;
    int exp_g[8];
    exp_g = '{0, 1, 2, 3, 0, 1, 2, 3};

    tbl[0] = '{1, 8'h05, 8'h03, 3'b000, 8'h08, 1'b0};
    tbl[1] = '{2, 8'h03, 8'h05, 3'b001, 8'hFE, 1'b0};
    tbl[2] = '{3, 8'hF0, 8'h3C, 3'b010, 8'h30, 1'b0};
    tbl[3] = '{0, 8'hF0, 8'h0F, 3'b011, 8'hFF, 1'b0};
    tbl[4] = '{3, 8'hF0, 8'h00, 3'b100, 8'h0F, 1'b0};
    tbl[5] = '{2, 8'hFF, 8'h00, 3'b110, 8'h00, 1'b1};
    tbl[6] = '{1, 8'hFF, 8'hFF, 3'b000, 8'hFE, 1'b0};
    tbl[7] = '{0, 8'h12, 8'h34, 3'b101, 8'h00, 1'b1};

    // Reset with requests pending: nothing may be accepted.
    rst_n = 1'b0;
    req_valid = 4'b1111;
    rsp_ready = '0;
    req_a = 32'h01020304;
    req_b = 32'h05060708;
    req_sel = '0;
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_outs", {rsp_data, 7'b0, rsp_err, alu_a, alu_b}, 0);
    chk("rst_sel_busy_cnt", {alu_sel, busy, op_count}, 0);
    @(negedge clk);
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_single(tbl[i]);

    // Reset during EXEC discards the operation.
    req_valid = 4'b0100;
    load(2, 8'h11, 8'h22, 3'b000);
    #1;
    chk("mid_accept", req_ready, 4'b0100);
    @(negedge clk);
    chk("mid_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_outs", {rsp_data, 7'b0, rsp_err, alu_a, alu_b}, 0);
    chk("mid_rst_sel_busy_cnt", {alu_sel, busy, op_count}, 0);
    exp_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_rst_hold", {rsp_valid, busy}, 0);
    end
    req_valid = '0;
    rst_n = 1'b1;

    // All requesters continuously valid, responses always accepted.
    for (int i = 0; i < 4; i++) load(i, 8'h03, 8'h05, 3'b001);
    req_valid = 4'b1111;
    rsp_ready = 4'b1111;
    ng = 0;
    last = 0;
    for (int c = 0; c < 40 && ng < 8; c++) begin
      #1;
      if (req_ready != 0) begin
        chk("rr_grant", req_ready, 32'(1) << exp_g[ng]);
        if (ng > 0) chk("rr_gap", c - last, 3);
        last = c;
        ng++;
      end
      if (rsp_valid != 0) chk("rr_data", rsp_data, 8'hFE);
      @(negedge clk);
    end
    chk("rr_grants", ng, 8);
    req_valid = '0;
    @(negedge clk);
    chk("rr_last_valid", rsp_valid, 4'b1000);
    @(negedge clk);
    exp_cnt += 8;
    chk("rr_count", op_count, exp_cnt % 16);

    // Backpressure on requester 2 while requester 0 waits.
    rsp_ready = '0;
    req_valid = 4'b0100;
    load(2, 8'hAA, 8'h0F, 3'b010);
    load(0, 8'h10, 8'h01, 3'b000);
    #1;
    chk("bp_accept", req_ready, 4'b0100);
    @(negedge clk);
    req_valid = 4'b0001;
    chk("bp_exec_ready", req_ready, 0);
    @(negedge clk);
    rsp_ready = 4'b1011;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_hold_valid", rsp_valid, 4'b0100);
      chk("bp_hold_data", rsp_data, 8'h0A);
      chk("bp_hold_ready", {req_ready, 3'b0, busy}, 1);
      @(negedge clk);
    end
    rsp_ready = 4'b0100;
    @(negedge clk);
    exp_cnt++;
    #1;
    chk("bp_release_busy", busy, 0);
    chk("bp_release_valid", rsp_valid, 0);
    chk("bp_next_grant", req_ready, 4'b0001);
    chk("bp_count", op_count, exp_cnt % 16);
    rsp_ready = 4'b0001;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    chk("bp2_valid", rsp_valid, 4'b0001);
    chk("bp2_data", rsp_data, 8'h11);
    @(negedge clk);
    exp_cnt++;
    rsp_ready = '0;

    // Seven more operations: 17 since reset, 4-bit counter reads 1.
    for (int i = 0; i < 7; i++) run_single(tbl[i]);
    chk("wrap_count", op_count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
